dn_benes_ctrl: RTL and testbench
================================

Name: dn_benes_ctrl

Overview:
- Configuration loader and run sequencer for the Benes distribution network (dn_benes).
- Accepts the per-router route bits as a stream of narrow words into a shadow register and presents them as a stable route_signals vector.
- On start, pulses set_en, then holds route_en while it admits a counted batch of input vectors.
- Tracks the network pipeline latency, so it flags output validity and signals completion after the last vector drains.

Parameters:
- N, 64, network width in elements (power of 2, at least 4).
- N_LEVELS, 2*$clog2(N)-1, router stages.
- CFG_W, 32, configuration word width.
- CFG_BITS, N_LEVELS*N/2, one route bit per router (derived).
- CFG_WORDS, ceil(CFG_BITS/CFG_W), words per configuration (derived).
- LAT, N_LEVELS, network latency in cycles from input to output.
- CNT_W, 16, batch length counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  config word accepted when high together with cfg_valid
- cfg_data  in  CFG_W  config word
- cfg_clear  in  1  discard the loaded configuration
- cfg_done  out  1  shadow register fully loaded
- start  in  1  begin a batch
- len  in  CNT_W  vectors in the batch, sampled on accepted start
- busy  out  1  batch in progress
- done  out  1  one-cycle pulse at batch end
- err  out  1  one-cycle pulse when start is rejected
- in_valid  in  1  upstream vector valid
- in_ready  out  1  controller admits the vector
- out_valid  out  1  network output valid this cycle
- set_en  out  1  to dn_benes
- route_en  out  1  to dn_benes
- route_signals  out  CFG_BITS  to dn_benes; bit index = level*N/2 + router position

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; shadow register, word counter, remaining counter and valid pipe cleared.
  - All outputs 0; route_signals 0.
  - Reset asserted mid-batch or mid-load abandons the operation, with no done or err pulse.
- States and transitions:
  - IDLE: cfg_ready = (word_cnt < CFG_WORDS).
    - An accepted word k is written to shadow bits [k*CFG_W +: CFG_W]; bits of the last word at or above CFG_BITS are dropped.
    - word_cnt increments; cfg_done = (word_cnt == CFG_WORDS).
    - cfg_clear zeroes word_cnt and cfg_done but leaves the shadow contents; it has priority over a same-cycle word acceptance.
    - start with cfg_done=0: err pulse next cycle, remain IDLE.
    - start with cfg_done=1 and len=0: done pulse next cycle, no set_en, remain IDLE.
    - start with cfg_done=1 and len>0: load the remaining counter with len, go to SET.
    - If start and cfg_clear arrive together, start is evaluated against the pre-clear cfg_done.
  - SET: exactly one cycle with set_en=1 and busy=1, then go to RUN.
  - RUN: route_en=1, in_ready=1. Each in_valid&&in_ready decrements the remaining counter. The accept on which remaining goes from 1 to 0 moves the state to DRAIN.
  - DRAIN: route_en=1, in_ready=0. When the valid pipe is empty, done pulses for one cycle and the state returns to IDLE.
- Configuration hold:
  - The shadow register is writable only in IDLE.
  - route_signals is driven directly from the shadow register, so it is stable from SET through DRAIN.
  - cfg_valid and cfg_clear are ignored while busy; cfg_ready=0 while busy.
  - cfg_done persists across batches, so back-to-back starts reuse the same routing without reloading.
- busy = 1 in SET, RUN and DRAIN.
- out_valid: a LAT-deep shift of (in_valid && in_ready).
  - The first vector accepted in cycle t gives out_valid in cycle t+LAT.
  - done is asserted the cycle after the last out_valid.
- start during busy is ignored, with no err pulse.
- Minimum batch length 1: SET, one RUN cycle, LAT DRAIN cycles, then done.

Decomposition:
- Package dn_pkg holds:
  - the state enum (IDLE, SET, RUN, DRAIN);
  - constant functions for N_LEVELS, CFG_BITS and CFG_WORDS, shared with dn_benes.
- One sub-module, dn_valid_pipe:
  - parameterised LAT-deep 1-bit shift register with asynchronous active-low clear;
  - outputs the tail bit and an empty flag (OR-reduce of all stages).

Test Plan:
Test configuration: N=8, CFG_W=8, so N_LEVELS=5, CFG_BITS=20, CFG_WORDS=3, LAT=5.
- Load words 0xA5, 0x3C, 0xFF -> route_signals=20'hF3CA5, cfg_done=1 after the third accept, then cfg_ready=0.
- Start with len=4 and in_valid held high:
  - set_en high one cycle;
  - route_en high from the RUN entry cycle through DRAIN, with 4 accepts;
  - out_valid high 4 consecutive cycles starting 5 cycles after the first accept;
  - done the cycle after the last out_valid, busy low the same cycle.
- Start with len=3 and in_valid toggling 1,0,1,0,1 -> out_valid pattern 1,0,1,0,1 delayed 5 cycles; remaining counter never underflows.
- Start before cfg_done, then start with len=0 after load -> err pulse, no busy; then done pulse with no set_en.
- Issue cfg_valid and cfg_clear during RUN -> both ignored and route_signals unchanged; after done, cfg_clear gives cfg_done=0.
- Drop reset during DRAIN -> all outputs 0 asynchronously, state IDLE, no done pulse; on release, a reload plus start completes normally.

Source files
------------

// File: rtl/dn_pkg.sv
// Shared types and sizing helpers for the Benes distribution network and its controller.
package dn_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSet,
        StRun,
        StDrain
    } dn_state_e;

    function automatic int unsigned n_levels(input int unsigned n);
        return 32'(2 * $clog2(n) - 1);
    endfunction

    // One route bit per 2x2 router across all stages.
    function automatic int unsigned cfg_bits(input int unsigned n);
        return n_levels(n) * n / 2;
    endfunction

    function automatic int unsigned cfg_words(input int unsigned n, input int unsigned w);
        return (cfg_bits(n) + w - 1) / w;
    endfunction

endpackage

// File: rtl/dn_valid_pipe.sv
// Shift register that tracks which network pipeline slots hold a valid vector.
module dn_valid_pipe #(
    parameter int unsigned LAT = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_i,
    output logic valid_o,
    output logic empty_o
);

    logic [LAT-1:0] stage_q;
    logic [LAT-1:0] stage_d;

    always_comb begin
        stage_d = LAT'({stage_q, in_i});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_o = stage_q[LAT-1];
    // Looks at the post-shift contents so the controller can end the batch on the last tail beat.
    assign empty_o = ~|stage_d;

endmodule

// File: rtl/dn_benes_ctrl.sv
// Configuration loader and run sequencer for dn_benes: shadow route register, batch counting,
// and pipeline-latency tracking for output valid and completion.
module dn_benes_ctrl
    import dn_pkg::*;
#(
    parameter int unsigned N     = 64,
    parameter int unsigned CFG_W = 32,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned LAT   = n_levels(N),
    localparam int unsigned CFG_BITS  = cfg_bits(N),
    localparam int unsigned CFG_WORDS = cfg_words(N, CFG_W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    input  logic                cfg_clear,
    output logic                cfg_done,
    input  logic                start,
    input  logic [CNT_W-1:0]    len,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    output logic                set_en,
    output logic                route_en,
    output logic [CFG_BITS-1:0] route_signals
);

    localparam int unsigned WCNT_W = $clog2(CFG_WORDS + 1);

    dn_state_e           state_q, state_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                cfg_done_q, cfg_done_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                in_ready_q, in_ready_d;
    logic                set_en_q, set_en_d;
    logic                route_en_q, route_en_d;

    logic                cfg_acc;
    logic                in_acc;
    logic                pipe_empty;
    logic [31:0]         shamt;
    logic [CFG_BITS-1:0] word_mask;
    logic [CFG_BITS-1:0] word_data;

    assign cfg_acc = cfg_valid && cfg_ready_q;
    assign in_acc  = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        shadow_d   = shadow_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        // Shifting within CFG_BITS drops any last-word bits beyond the route vector.
        shamt     = 32'(word_cnt_q) * CFG_W;
        word_mask = CFG_BITS'({CFG_W{1'b1}}) << shamt;
        word_data = CFG_BITS'(cfg_data) << shamt;

        unique case (state_q)
            StIdle: begin
                if (cfg_clear) begin
                    word_cnt_d = '0;
                end else if (cfg_acc) begin
                    word_cnt_d = word_cnt_q + WCNT_W'(1);
                    shadow_d   = (shadow_q & ~word_mask) | word_data;
                end
                // Judged against the registered cfg_done, i.e. before any same-cycle clear.
                if (start) begin
                    if (!cfg_done_q) begin
                        err_d = 1'b1;
                    end else if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = len;
                        state_d = StSet;
                    end
                end
            end
            StSet: begin
                state_d = StRun;
            end
            StRun: begin
                if (in_acc) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pipe_empty) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        cfg_ready_d = (state_d == StIdle) && (word_cnt_d < WCNT_W'(CFG_WORDS));
        cfg_done_d  = (word_cnt_d == WCNT_W'(CFG_WORDS));
        busy_d      = (state_d != StIdle);
        set_en_d    = (state_d == StSet);
        in_ready_d  = (state_d == StRun);
        route_en_d  = (state_d == StRun) || (state_d == StDrain);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            word_cnt_q  <= '0;
            shadow_q    <= '0;
            rem_q       <= '0;
            cfg_ready_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            set_en_q    <= 1'b0;
            route_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            shadow_q    <= shadow_d;
            rem_q       <= rem_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_done_q  <= cfg_done_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            set_en_q    <= set_en_d;
            route_en_q  <= route_en_d;
        end
    end

    dn_valid_pipe #(
        .LAT (LAT)
    ) u_valid_pipe (
        .clk_i   (clk),
        .rst_ni  (reset),
        .in_i    (in_acc),
        .valid_o (out_valid),
        .empty_o (pipe_empty)
    );

    assign cfg_ready     = cfg_ready_q;
    assign cfg_done      = cfg_done_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign in_ready      = in_ready_q;
    assign set_en        = set_en_q;
    assign route_en      = route_en_q;
    assign route_signals = shadow_q;

endmodule

// File: tb/tb_dn_benes_ctrl.sv
// Scoreboard bench for dn_benes_ctrl at N=8, CFG_W=8: stimulus tasks queue expected event
// cycles from a cycle-level model; a negedge monitor pops and compares.
module tb_dn_benes_ctrl;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_data = '0;
    logic        cfg_clear = 1'b0;
    logic        cfg_done;
    logic        start = 1'b0;
    logic [15:0] len_r = '0;
    logic        busy, done, err;
    logic        in_valid = 1'b0;
    logic        in_ready, out_valid, set_en, route_en;
    logic [19:0] route_signals;

    dn_benes_ctrl #(
        .N     (8),
        .CFG_W (8),
        .CNT_W (16),
        .LAT   (LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_data      (cfg_data),
        .cfg_clear     (cfg_clear),
        .cfg_done      (cfg_done),
        .start         (start),
        .len           (len_r),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .set_en        (set_en),
        .route_en      (route_en),
        .route_signals (route_signals)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event kinds: 0 out_valid, 1 done, 2 err, 3 set_en.
    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t         evq[$];
    bit          exp_busy[int];
    bit          exp_route[int];
    bit          exp_inrdy[int];
    logic [23:0] m_wide = '0;
    int          m_wc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    string       ev_name[4] = '{"out_valid", "done", "err", "set_en"};

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    function automatic void push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        evq.push_back(e);
    endfunction

    function automatic void flush_model();
        evq.delete();
        exp_busy.delete();
        exp_route.delete();
        exp_inrdy.delete();
        m_wide = '0;
        m_wc   = 0;
    endfunction

    always @(negedge clk) begin
        bit ev_exp[4];
        bit ev_act[4];
        if (reset) begin
            ev_exp = '{default: 1'b0};
            while (evq.size() > 0 && evq[0].at <= cyc) begin
                if (evq[0].at < cyc) check("missed_event_cycle", evq[0].at, cyc);
                ev_exp[evq[0].kind] = 1'b1;
                void'(evq.pop_front());
            end
            ev_act = '{out_valid, done, err, set_en};
            for (int k = 0; k < 4; k++) begin
                if (ev_act[k] || ev_exp[k]) check(ev_name[k], ev_act[k], ev_exp[k]);
            end
            check("busy", busy, exp_busy.exists(cyc));
            check("route_en", route_en, exp_route.exists(cyc));
            check("in_ready", in_ready, exp_inrdy.exists(cyc));
            check("cfg_done", cfg_done, m_wc == 3);
            check("route_signals", route_signals, m_wide[19:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, done, err, in_ready, out_valid, set_en, route_en, cfg_ready,
                     cfg_done, route_signals}, 0);
    endtask

    task automatic load_word(input logic [7:0] d);
        bit got = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = cfg_ready;
        end
        check("cfg_handshake", got, 1);
        step();
        cfg_valid = 1'b0;
        if (got) begin
            m_wide[m_wc*8 +: 8] = d;
            m_wc++;
        end
    endtask

    task automatic clear_cfg();
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        m_wc = 0;
    endtask

    task automatic drive_noise();
        cfg_valid = 1'b1;
        cfg_data  = 8'($urandom);
        cfg_clear = 1'($urandom_range(0, 1));
    endtask

    task automatic do_abort();
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        flush_model();
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        cfg_clear = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // mode 0: in_valid held, 1: alternating from 1, 2: random.
    task automatic run_batch(input int n, input int mode, input bit noise, input bit abort);
        int s, c, acc, tries, last;
        bit iv;
        s = cyc;
        start = 1'b1;
        len_r = 16'(n);
        if (m_wc != 3 || n == 0) begin
            push((m_wc != 3) ? 2 : 1, s + 1);
            step();
            start = 1'b0;
            step();
            return;
        end
        push(3, s + 1);
        exp_busy[s + 1] = 1'b1;
        step();
        start    = 1'b0;
        len_r    = 16'($urandom);
        in_valid = 1'($urandom_range(0, 1));
        if (noise) drive_noise();
        step();
        acc   = 0;
        tries = 0;
        while (acc < n) begin
            c = cyc;
            exp_busy[c]  = 1'b1;
            exp_route[c] = 1'b1;
            exp_inrdy[c] = 1'b1;
            case (mode)
                0:       iv = 1'b1;
                1:       iv = (tries % 2 == 0);
                default: iv = (tries > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            in_valid = iv;
            if (noise) drive_noise();
            if (iv) begin
                acc++;
                push(0, c + LAT);
            end
            tries++;
            step();
        end
        last      = cyc - 1;
        cfg_valid = 1'b0;
        cfg_clear = 1'b0;
        for (int d = last + 1; d <= last + LAT; d++) begin
            exp_busy[d]  = 1'b1;
            exp_route[d] = 1'b1;
        end
        push(1, last + LAT + 1);
        for (int i = 0; i <= LAT; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            if (abort && i == 2) begin
                do_abort();
                return;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        check_all_zero("reset_outputs");
        reset = 1'b1;
        step();

        // Start before any configuration: error pulse only.
        run_batch(5, 0, 1'b0, 1'b0);

        load_word(8'hA5);
        load_word(8'h3C);
        load_word(8'hFF);
        check("route_after_load", route_signals, 20'hF3CA5);
        check("cfg_done_after_load", cfg_done, 1);
        check("cfg_ready_after_load", cfg_ready, 0);

        run_batch(0, 0, 1'b0, 1'b0);
        run_batch(4, 0, 1'b0, 1'b0);
        run_batch(3, 1, 1'b0, 1'b0);
        run_batch(1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_batch($urandom_range(1, 6), 2, 1'(i), 1'b0);
        end

        // Config traffic during a run must leave routing untouched.
        run_batch(5, 0, 1'b1, 1'b0);
        check("route_after_noise", route_signals, 20'hF3CA5);
        clear_cfg();
        check("cfg_done_after_clear", cfg_done, 0);
        check("route_kept_after_clear", route_signals, 20'hF3CA5);
        run_batch(2, 0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) load_word(8'($urandom));
        run_batch(4, 0, 1'b0, 1'b1);
        check("route_cleared_by_reset", route_signals, 0);
        step();
        for (int i = 0; i < 3; i++) load_word(8'($urandom));
        run_batch(2, 0, 1'b0, 1'b0);
        run_batch(3, 2, 1'b0, 1'b0);

        step();
        step();
        check("pending_events", evq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
